// File: rtl/i_cache_refill.sv
// Instruction-cache miss handler: de-duplicates up to two line misses, bursts each line from memory,
// and writes the assembled line to the cache. Optional counters under I_CACHE_REFILL_PERF_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module i_cache_refill #(
   parameter int LINE_SIZE = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [1:0]                  miss_valid,
   input  logic [`ADDR_WIDTH-1:0]      miss_addr [2],
   input  logic                        flush,
   output logic                        mem_req_valid,
   input  logic                        mem_req_ready,
   output logic [`ADDR_WIDTH-1:0]      mem_req_addr,
   input  logic                        mem_resp_valid,
   input  logic [31:0]                 mem_resp_data,
   output logic [`ADDR_WIDTH-1:0]      fetch_addr,
   output logic                        fetch_addr_valid,
   output logic [32*LINE_SIZE-1:0]     fetched_data,
   output logic                        busy,
   output logic [1:0]                  state_dbg
`ifdef I_CACHE_REFILL_PERF_EN
   ,
   output logic [31:0]                 perf_refills,
   output logic [31:0]                 perf_dedup,
   output logic [31:0]                 perf_stall_cycles
`endif
);

   // Request handshake: mem_req_addr is held stable while mem_req_valid is high;
   // a transfer happens on the rising edge where mem_req_valid && mem_req_ready.
   localparam int AW  = `ADDR_WIDTH;
   localparam int OFF = 2 + $clog2(LINE_SIZE);
   localparam int CW  = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_SIZE - 1);

   typedef enum logic [1:0] {IDLE, REQ, COLLECT, WRITE} state_t;

   state_t                          state_q, state_d;
   logic [1:0]                      slot_v_q, slot_v_d;
   logic [1:0][AW-1:0]              slot_a_q, slot_a_d;
   logic [CW-1:0]                   cnt_q, cnt_d;
   logic                            drop_q, drop_d;
   logic [LINE_SIZE-1:0][31:0]      line_q, line_d;
   logic [32*LINE_SIZE-1:0]         fdata_q, fdata_d;
   logic [AW-1:0]                   faddr_q, faddr_d;
   logic [AW-1:0]                   a0, a1;

   assign a0 = {miss_addr[0][AW-1:OFF], {OFF{1'b0}}};
   assign a1 = {miss_addr[1][AW-1:OFF], {OFF{1'b0}}};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         slot_v_q <= '0;
         slot_a_q <= '0;
         cnt_q    <= '0;
         drop_q   <= 1'b0;
         line_q   <= '0;
         fdata_q  <= '0;
         faddr_q  <= '0;
      end else begin
         state_q  <= state_d;
         slot_v_q <= slot_v_d;
         slot_a_q <= slot_a_d;
         cnt_q    <= cnt_d;
         drop_q   <= drop_d;
         line_q   <= line_d;
         fdata_q  <= fdata_d;
         faddr_q  <= faddr_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      slot_v_d         = slot_v_q;
      slot_a_d         = slot_a_q;
      cnt_d            = cnt_q;
      drop_d           = drop_q;
      line_d           = line_q;
      fdata_d          = fdata_q;
      faddr_d          = faddr_q;
      mem_req_valid    = 1'b0;
      mem_req_addr     = '0;
      fetch_addr_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (!flush && (|miss_valid)) begin
               state_d     = REQ;
               drop_d      = 1'b0;
               cnt_d       = '0;
               slot_v_d[0] = 1'b1;
               slot_a_d[1] = a1;
               if (miss_valid[0]) begin
                  slot_a_d[0] = a0;
                  slot_v_d[1] = miss_valid[1] && (a1 != a0);
               end else begin
                  slot_a_d[0] = a1;
                  slot_v_d[1] = 1'b0;
               end
            end
         end
         REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = slot_a_q[0];
            if (mem_req_ready) begin
               state_d = COLLECT;
               cnt_d   = '0;
               drop_d  = flush;
               if (flush) slot_v_d[1] = 1'b0;
            end else if (flush) begin
               state_d  = IDLE;
               slot_v_d = '0;
            end
         end
         COLLECT: begin
            if (flush) begin
               drop_d      = 1'b1;
               slot_v_d[1] = 1'b0;
            end
            if (mem_resp_valid) begin
               for (int k = 0; k < LINE_SIZE; k++) begin
                  if (cnt_q == CW'(k)) line_d[k] = mem_resp_data;
               end
               if (cnt_q == LAST_BEAT) begin
                  cnt_d = '0;
                  // A flush on the final beat abandons the line just like an earlier one.
                  if (drop_q || flush) begin
                     state_d  = IDLE;
                     slot_v_d = '0;
                     drop_d   = 1'b0;
                  end else begin
                     state_d = WRITE;
                     fdata_d = line_d;
                     faddr_d = slot_a_q[0];
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         WRITE: begin
            fetch_addr_valid = 1'b1;
            if (flush) begin
               state_d  = IDLE;
               slot_v_d = '0;
            end else if (slot_v_q[1]) begin
               state_d     = REQ;
               slot_a_d[0] = slot_a_q[1];
               slot_v_d[1] = 1'b0;
            end else begin
               state_d     = IDLE;
               slot_v_d[0] = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign fetch_addr   = faddr_q;
   assign fetched_data = fdata_q;
   assign busy         = (state_q != IDLE);
   assign state_dbg    = state_q;

`ifdef I_CACHE_REFILL_PERF_EN
   logic [31:0] refills_q, dedup_q, stall_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         refills_q <= '0;
         dedup_q   <= '0;
         stall_q   <= '0;
      end else begin
         if (state_q == WRITE && refills_q != '1) refills_q <= refills_q + 1'b1;
         if (state_q == IDLE && !flush && miss_valid == 2'b11 && a0 == a1 && dedup_q != '1)
            dedup_q <= dedup_q + 1'b1;
         if ((state_q == REQ || state_q == COLLECT) && stall_q != '1) stall_q <= stall_q + 1'b1;
      end
   end

   assign perf_refills      = refills_q;
   assign perf_dedup        = dedup_q;
   assign perf_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_i_cache_refill.sv
// Bench for i_cache_refill: directed scenarios plus randomized misses checked against a line-list model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_i_cache_refill;
   localparam int LS  = 2;
   localparam int AW  = `ADDR_WIDTH;
   localparam int OFF = 2 + $clog2(LS);
   localparam int DW  = 32 * LS;

   logic          clk, reset;
   logic [1:0]    miss_valid;
   logic [AW-1:0] miss_addr [2];
   logic          flush;
   logic          mem_req_valid, mem_req_ready;
   logic [AW-1:0] mem_req_addr;
   logic          mem_resp_valid;
   logic [31:0]   mem_resp_data;
   logic [AW-1:0] fetch_addr;
   logic          fetch_addr_valid;
   logic [DW-1:0] fetched_data;
   logic          busy;
   logic [1:0]    state_dbg;
`ifdef I_CACHE_REFILL_PERF_EN
   logic [31:0]   perf_refills, perf_dedup, perf_stall_cycles;
`endif

   i_cache_refill #(.LINE_SIZE(LS)) dut (
      .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_addr(miss_addr), .flush(flush),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .fetch_addr(fetch_addr), .fetch_addr_valid(fetch_addr_valid), .fetched_data(fetched_data),
      .busy(busy), .state_dbg(state_dbg)
`ifdef I_CACHE_REFILL_PERF_EN
      , .perf_refills(perf_refills), .perf_dedup(perf_dedup), .perf_stall_cycles(perf_stall_cycles)
`endif
   );

   int            vectors = 0;
   int            errors  = 0;
   int            cyc     = 0;
   int            strobes = 0;
   logic [AW-1:0] exp_q [$];
   logic [DW-1:0] line_model;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) if (fetch_addr_valid) strobes++;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
      logic [AW-1:0] r;
      r = a;
      r[OFF-1:0] = '0;
      return r;
   endfunction

   // Model: the lines to fetch are the distinct lines of the valid misses, slot 0 first.
   task automatic refill(input logic [1:0] mv, input logic [AW-1:0] ad0, input logic [AW-1:0] ad1,
                         input int stall_max, input int gap_max, input bit chk_lat);
      int            t0, n, s0, nlines;
      bit            dup;
      logic [AW-1:0] cur;
      logic [31:0]   w;
      exp_q = {};
      if (mv[0]) exp_q.push_back(line_of(ad0));
      if (mv[1]) begin
         dup = 1'b0;
         foreach (exp_q[i]) if (exp_q[i] == line_of(ad1)) dup = 1'b1;
         if (!dup) exp_q.push_back(line_of(ad1));
      end
      nlines = exp_q.size();
      s0 = strobes;
      miss_valid = mv; miss_addr[0] = ad0; miss_addr[1] = ad1;
      t0 = cyc;
      step();
      miss_valid = 2'b00; miss_addr[0] = AW'($urandom); miss_addr[1] = AW'($urandom);
      while (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         n = 0;
         while (!mem_req_valid && n < 20) begin step(); n++; end
         chk("req_timeout", (n < 20), 1);
         if (n >= 20) return;
         chk("req_addr", mem_req_addr, cur);
         repeat ($urandom_range(0, stall_max)) begin
            step();
            chk("req_valid_hold", mem_req_valid, 1);
            chk("req_addr_hold", mem_req_addr, cur);
         end
         mem_req_ready = 1'b1;
         step();
         mem_req_ready = 1'b0;
         for (int k = 0; k < LS; k++) begin
            repeat ($urandom_range(0, gap_max)) step();
            w = $urandom;
            mem_resp_valid = 1'b1; mem_resp_data = w;
            line_model[32*k +: 32] = w;
            step();
            mem_resp_valid = 1'b0; mem_resp_data = $urandom;
         end
         chk("strobe", fetch_addr_valid, 1);
         chk("fetch_addr", fetch_addr, cur);
         chk("fetched_data", fetched_data, line_model);
         if (chk_lat) chk("latency", cyc - t0, LS + 2);
         step();
         chk("strobe_len", fetch_addr_valid, 0);
         chk("data_hold", fetched_data, line_model);
      end
      chk("idle_after", busy, 0);
      chk("strobe_count", strobes - s0, nlines);
   endtask

   initial begin
      logic [AW-1:0] prev_addr, r0, r1;
      logic [DW-1:0] prev_data;
      int            s0;
      reset = 1'b0; miss_valid = 2'b00; miss_addr[0] = '0; miss_addr[1] = '0; flush = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      repeat (3) step();
      chk("rst_busy", busy, 0);
      chk("rst_req_valid", mem_req_valid, 0);
      chk("rst_req_addr", mem_req_addr, 0);
      chk("rst_strobe", fetch_addr_valid, 0);
      chk("rst_fetch_addr", fetch_addr, 0);
      chk("rst_fetched_data", fetched_data, 0);
      chk("rst_state", state_dbg, 0);
      reset = 1'b1;
      step();

      // Single miss at minimum latency.
      refill(2'b01, 'h104, 'h0, 0, 0, 1);
      // Same line in both slots, then two distinct lines, then slot 1 alone.
      refill(2'b11, 'h200, 'h204, 2, 1, 0);
      refill(2'b11, 'h200, 'h308, 2, 2, 0);
      refill(2'b10, 'hDEAD0, 'h30C, 1, 1, 0);

      // Flush while the request is stalled.
      s0 = strobes;
      miss_valid = 2'b01; miss_addr[0] = 'h500;
      step();
      miss_valid = 2'b00;
      step(); step();
      chk("flreq_busy_before", busy, 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flreq_busy_after", busy, 0);
      chk("flreq_req_valid", mem_req_valid, 0);
      repeat (2) step();
      chk("flreq_no_strobe", strobes - s0, 0);

      // Flush during COLLECT after beat 0.
      s0 = strobes; prev_addr = fetch_addr; prev_data = fetched_data;
      miss_valid = 2'b01; miss_addr[0] = 'h600;
      step();
      miss_valid = 2'b00; mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = $urandom;
      step();
      mem_resp_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flcol_busy_mid", busy, 1);
      mem_resp_valid = 1'b1; mem_resp_data = $urandom;
      step();
      mem_resp_valid = 1'b0;
      chk("flcol_busy_after", busy, 0);
      repeat (2) step();
      chk("flcol_no_strobe", strobes - s0, 0);
      chk("flcol_addr_hold", fetch_addr, prev_addr);
      chk("flcol_data_hold", fetched_data, prev_data);
      refill(2'b01, 'h400, 'h0, 1, 1, 0);

      // Reset asserted mid-COLLECT.
      miss_valid = 2'b01; miss_addr[0] = 'h700;
      step();
      miss_valid = 2'b00; mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF_FFFF;
      step();
      mem_resp_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_req_valid", mem_req_valid, 0);
      chk("midrst_req_addr", mem_req_addr, 0);
      chk("midrst_strobe", fetch_addr_valid, 0);
      chk("midrst_fetch_addr", fetch_addr, 0);
      chk("midrst_fetched_data", fetched_data, 0);
      step();
      reset = 1'b1;
      step();
      refill(2'b01, 'h10, 'h0, 0, 0, 1);

      // Randomized misses with frequent same-line pairs.
      for (int t = 0; t < 24; t++) begin
         r0 = AW'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 15) << 2));
         r1 = ($urandom_range(0, 1) == 1) ? (r0 ^ AW'(4))
              : AW'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 15) << 2));
         refill(2'($urandom_range(1, 3)), r0, r1, 3, 2, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/i_cache_refill.md
Name: i_cache_refill

Overview:
- Miss handler on the memory side of the instruction cache; it is the producer for the cache's refill port.
- Captures up to two outstanding miss addresses from fetch, de-duplicates them by cache line, and issues one line-aligned burst request per line on a valid/ready memory request channel.
- Assembles LINE_SIZE 32-bit response beats into one line and presents it as a one-cycle `fetch_addr` / `fetch_addr_valid` / `fetched_data` write to the cache.

Parameters:
- LINE_SIZE, 2, 32-bit words per cache line (power of two, >=1); must equal the cache's LINE_SIZE.
- `ADDR_WIDTH (macro from riscv_core.svh), byte address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- miss_valid  in  [2] x 1  miss request per fetch slot
- miss_addr  in  [2] x `ADDR_WIDTH  byte address of each missing instruction
- flush  in  1  abandon pending refills
- mem_req_valid  out  1  burst request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  `ADDR_WIDTH  line-aligned byte address; low 2+$clog2(LINE_SIZE) bits are zero
- mem_resp_valid  in  1  one response beat valid; no backpressure
- mem_resp_data  in  32  response word, lowest address first
- fetch_addr  out  `ADDR_WIDTH  line-aligned address of the completed line
- fetch_addr_valid  out  1  one-cycle line write strobe to the cache
- fetched_data  out  32*LINE_SIZE  assembled line; beat k occupies bits [32k +: 32]
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all outputs 0; both pending slots invalid; beat counter 0; drop flag 0.
- FSM has four states: IDLE, REQ, COLLECT, WRITE.
- IDLE:
  - If flush=0 and any miss_valid, latch both slots: valid, line-aligned address.
  - If both slots are valid and hold the same line, invalidate slot 1.
  - If only miss_valid[1] is set, it is stored in slot 0.
  - Next state is REQ. Misses presented outside IDLE are ignored; the cache re-presents them.
- REQ:
  - mem_req_valid=1, mem_req_addr = slot 0 address; held stable until accepted.
  - On valid&&ready: go to COLLECT, beat counter=0.
  - flush without ready: return to IDLE and clear both slots.
  - flush with ready in the same cycle: go to COLLECT with drop=1 and clear slot 1.
- COLLECT:
  - Each mem_resp_valid writes the beat at index counter; counter increments.
  - On the beat where counter==LINE_SIZE-1: go to WRITE, or go to IDLE if drop is set.
  - flush during COLLECT sets drop=1 and clears slot 1; remaining beats are still consumed.
  - The beat counter is at least 1 bit wide, so LINE_SIZE=1 is legal.
- WRITE (exactly one cycle):
  - fetch_addr_valid=1, fetch_addr = slot 0 address, fetched_data = line.
  - Then if slot 1 is valid: move slot 1 into slot 0 and go to REQ; else go to IDLE.
  - flush during WRITE: the write still completes, slot 1 is cleared, and the next state is IDLE.
- mem_resp_valid outside COLLECT is ignored.
- fetched_data and fetch_addr hold their last values when not strobed; only fetch_addr_valid is qualifying.
- Minimum latency, single miss, ready=1, beats back-to-back: capture at cycle 0, request at cycle 1, beats at cycles 2..LINE_SIZE+1, write strobe at cycle LINE_SIZE+2.

Optional Feature:
- Macro: I_CACHE_REFILL_PERF_EN.
- When defined, adds three outputs, each cleared by reset and saturating at all-ones:
  - perf_refills [31:0]: counts WRITE cycles.
  - perf_dedup [31:0]: counts IDLE captures where the two slots held the same line.
  - perf_stall_cycles [31:0]: counts cycles in REQ or COLLECT.
- When undefined, these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- LINE_SIZE=2, miss_valid={1,0}, miss_addr[0]=0x104, ready=1, beats 0xAAAA0001 then 0xBBBB0002 -> mem_req_addr=0x100 in cycle 1; fetch_addr=0x100, fetched_data=0xBBBB0002_AAAA0001, fetch_addr_valid high for exactly one cycle at cycle 4.
- Both slots valid, addresses 0x200 and 0x204 (same line) -> exactly one request (0x200) and one write strobe.
- Addresses 0x200 and 0x308 -> requests 0x200 then 0x308 in that order; two write strobes, second with fetch_addr=0x308.
- mem_req_ready held 0 for 5 cycles, flush pulsed in cycle 3 -> no accept occurs, state returns to IDLE, no write strobe, busy=0 the next cycle.
- flush during COLLECT after beat 0 -> beat 1 is consumed, fetch_addr_valid never asserts, and a subsequent miss at 0x400 refills correctly.
- reset driven low mid-COLLECT -> all outputs 0 immediately; after release, a miss at 0x10 produces mem_req_addr=0x10 with no stale data in the new line.
